// File: rtl/alu_result_writeback.sv
// ---------------------------------------------------------------------------
// alu_result_writeback
//
// Writeback stage for the 16-bit ALU result. One request on wb_start (taken
// only while idle) captures alu_result and a one-hot/multi-hot destination
// mask. The following cycle strobes every selected destination at once.
// A write to the memory data register goes through an 8-bit port, so it
// takes a second cycle for the high byte.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   wb_start             request strobe, ignored while busy
//   wb_select            destination mask: [0] regfile 16-bit, [1] mem addr,
//                        [2] mem din, [3] PC, [4] int ctrl; zero = regfile 8-bit
//   alu_result           value to write back
//   busy, done           handshake: busy through the whole write, done in last cycle
//   regfile_we_8bit/16bit, regfile_din       register file strobes and data
//   reg_mem_addr_we                          memory address register strobe
//   reg_mem_din_lo_we/hi_we, reg_mem_din_byte  memory data register byte writes
//   reg_pc_we, reg_int_ctrl_we               PC / interrupt-control strobes
//   wb_data              captured result, shared bus for addr/PC/int ctrl
// ---------------------------------------------------------------------------
module alu_result_writeback #(
    parameter int WB_SEL_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_start,
    input  logic [WB_SEL_WIDTH-1:0] wb_select,
    input  logic [15:0]             alu_result,
    output logic                    busy,
    output logic                    done,
    output logic                    regfile_we_8bit,
    output logic                    regfile_we_16bit,
    output logic [15:0]             regfile_din,
    output logic                    reg_mem_addr_we,
    output logic                    reg_mem_din_lo_we,
    output logic                    reg_mem_din_hi_we,
    output logic [7:0]              reg_mem_din_byte,
    output logic                    reg_pc_we,
    output logic                    reg_int_ctrl_we,
    output logic [15:0]             wb_data
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_WRITE_HI = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_res;
    logic        r_sel_mem;     // only the mem-din bit matters after capture
    logic        r_busy;
    logic        r_done;
    logic        r_we_8;
    logic        r_we_16;
    logic        r_addr_we;
    logic        r_lo_we;
    logic        r_hi_we;
    logic        r_pc_we;
    logic        r_int_we;
    logic [7:0]  r_byte;

    // Destination bits the block knows about; wider masks are truncated and
    // narrower ones zero-extended, so nonexistent destinations never strobe.
    logic [4:0]  w_sel;
    assign w_sel = 5'(wb_select);

    // Enables are computed at the accepting edge so they appear registered
    // in the WRITE cycle without any input-to-output combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_res     <= '0;
            r_sel_mem <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_we_8    <= 1'b0;
            r_we_16   <= 1'b0;
            r_addr_we <= 1'b0;
            r_lo_we   <= 1'b0;
            r_hi_we   <= 1'b0;
            r_pc_we   <= 1'b0;
            r_int_we  <= 1'b0;
            r_byte    <= '0;
        end else begin
            // Every strobe is single-cycle; default them low each edge.
            r_done    <= 1'b0;
            r_we_8    <= 1'b0;
            r_we_16   <= 1'b0;
            r_addr_we <= 1'b0;
            r_lo_we   <= 1'b0;
            r_hi_we   <= 1'b0;
            r_pc_we   <= 1'b0;
            r_int_we  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_start) begin
                        r_res     <= alu_result;
                        r_sel_mem <= w_sel[2];
                        r_busy    <= 1'b1;
                        r_we_8    <= (w_sel == 5'd0);
                        r_we_16   <= w_sel[0];
                        r_addr_we <= w_sel[1];
                        r_lo_we   <= w_sel[2];
                        r_pc_we   <= w_sel[3];
                        r_int_we  <= w_sel[4];
                        r_byte    <= alu_result[7:0];
                        // Single-cycle writes finish in WRITE itself.
                        r_done    <= ~w_sel[2];
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_sel_mem) begin
                        r_hi_we <= 1'b1;
                        r_byte  <= r_res[15:8];
                        r_done  <= 1'b1;
                        r_state <= S_WRITE_HI;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE_HI: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign regfile_we_8bit   = r_we_8;
    assign regfile_we_16bit  = r_we_16;
    assign regfile_din       = r_res;
    assign reg_mem_addr_we   = r_addr_we;
    assign reg_mem_din_lo_we = r_lo_we;
    assign reg_mem_din_hi_we = r_hi_we;
    assign reg_mem_din_byte  = r_byte;
    assign reg_pc_we         = r_pc_we;
    assign reg_int_ctrl_we   = r_int_we;
    assign wb_data           = r_res;

endmodule

// File: tb/tb_alu_result_writeback.sv
module tb_alu_result_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_start;
    logic [4:0]  wb_select;
    logic [15:0] alu_result;
    logic        busy, done;
    logic        regfile_we_8bit, regfile_we_16bit;
    logic [15:0] regfile_din;
    logic        reg_mem_addr_we, reg_mem_din_lo_we, reg_mem_din_hi_we;
    logic [7:0]  reg_mem_din_byte;
    logic        reg_pc_we, reg_int_ctrl_we;
    logic [15:0] wb_data;

    int checks   = 0;
    int failures = 0;

    alu_result_writeback #(.WB_SEL_WIDTH(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_start         (wb_start),
        .wb_select        (wb_select),
        .alu_result       (alu_result),
        .busy             (busy),
        .done             (done),
        .regfile_we_8bit  (regfile_we_8bit),
        .regfile_we_16bit (regfile_we_16bit),
        .regfile_din      (regfile_din),
        .reg_mem_addr_we  (reg_mem_addr_we),
        .reg_mem_din_lo_we(reg_mem_din_lo_we),
        .reg_mem_din_hi_we(reg_mem_din_hi_we),
        .reg_mem_din_byte (reg_mem_din_byte),
        .reg_pc_we        (reg_pc_we),
        .reg_int_ctrl_we  (reg_int_ctrl_we),
        .wb_data          (wb_data)
    );

    always #5 clk = ~clk;

    // Enable vector order: {we8, we16, addr, lo, hi, pc, int}
    function automatic logic [6:0] enables();
        return {regfile_we_8bit, regfile_we_16bit, reg_mem_addr_we,
                reg_mem_din_lo_we, reg_mem_din_hi_we, reg_pc_we, reg_int_ctrl_we};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a request produces a list of write cycles. Cycle 1 writes
    // every selected destination (zero mask -> 8-bit regfile) plus the low
    // byte when mem din is selected; a mem din request adds a high-byte cycle.
    task automatic do_txn(input logic [4:0] sel, input logic [15:0] res, input bit inject);
        int          n;
        logic [6:0]  exp_en;
        logic [7:0]  exp_byte;
        wb_start   = 1'b1;
        wb_select  = sel;
        alu_result = res;
        tick();
        wb_start   = 1'b0;
        n = sel[2] ? 2 : 1;
        for (int c = 1; c <= n; c++) begin
            if (c == 1) begin
                exp_en   = {sel == 5'd0, sel[0], sel[1], sel[2], 1'b0, sel[3], sel[4]};
                exp_byte = res[7:0];
            end else begin
                exp_en   = 7'b0000100;
                exp_byte = res[15:8];
            end
            chk($sformatf("en_c%0d_sel%b", c, sel), 16'(enables()), 16'(exp_en));
            chk($sformatf("busy_c%0d", c), 16'(busy), 16'd1);
            chk($sformatf("done_c%0d", c), 16'(done), 16'(c == n));
            chk("regfile_din", regfile_din, res);
            chk("wb_data", wb_data, res);
            if (sel[2]) chk($sformatf("byte_c%0d", c), 16'(reg_mem_din_byte), 16'(exp_byte));
            if (inject) begin
                // A start while busy must be ignored entirely.
                wb_start   = 1'b1;
                wb_select  = ~sel;
                alu_result = ~res;
            end
            tick();
            wb_start = 1'b0;
        end
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_done", 16'(done), 16'd0);
        chk("idle_en", 16'(enables()), 16'd0);
        chk("idle_wb_data", wb_data, res);
    endtask

    initial begin
        reset      = 1'b1;
        wb_start   = 1'b0;
        wb_select  = '0;
        alu_result = '0;
        #3;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_en", 16'(enables()), 16'd0);
        chk("rst_regfile_din", regfile_din, 16'd0);
        chk("rst_wb_data", wb_data, 16'd0);
        chk("rst_byte", 16'(reg_mem_din_byte), 16'd0);
        tick();
        reset = 1'b0;
        tick();

        // Directed cases
        do_txn(5'b00000, 16'h12AB, 1'b0);
        do_txn(5'b01000, 16'h8000, 1'b0);
        do_txn(5'b00100, 16'hBEEF, 1'b0);
        do_txn(5'b00111, 16'h4321, 1'b0);
        do_txn(5'b10000, 16'h00A5, 1'b1);
        do_txn(5'b00100, 16'hCAFE, 1'b1);
        do_txn(5'b11111, 16'hFFFF, 1'b0);

        // Randomized requests, some with starts injected while busy
        for (int i = 0; i < 40; i++) begin
            do_txn(5'($urandom_range(0, 31)), 16'($urandom), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Asynchronous reset in the middle of WRITE_HI
        wb_start   = 1'b1;
        wb_select  = 5'b00100;
        alu_result = 16'h5A3C;
        tick();
        wb_start = 1'b0;
        chk("pre_rst_lo", 16'(reg_mem_din_lo_we), 16'd1);
        tick();
        chk("pre_rst_hi", 16'(reg_mem_din_hi_we), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_en", 16'(enables()), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_done", 16'(done), 16'd0);
        chk("mid_rst_wb_data", wb_data, 16'd0);
        chk("mid_rst_byte", 16'(reg_mem_din_byte), 16'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 16'(busy), 16'd0);
        chk("post_rst_en", 16'(enables()), 16'd0);
        do_txn(5'b00010, 16'h1357, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
